// File: rtl/max3421e_spi_master.sv
// Transaction-level SPI master for the MAX3421E: one command byte followed by
// len data bytes, mode 0, with the command-phase status byte captured.
module max3421e_spi_master #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [4:0]       reg_in,
  input  logic             write_in,
  input  logic             ackstat_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic [7:0]       tx_data_in,
  output logic             tx_ready_out,
  output logic [7:0]       rx_data_out,
  output logic             rx_valid_out,
  output logic [7:0]       status_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             ss_out,
  output logic             sclk_out,
  output logic             mosi_out,
  input  logic             miso_in
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [DIV_W-1:0] r_div;
  logic             r_phaseHigh;
  logic [2:0]       r_bitCnt;
  logic [LEN_W-1:0] r_bytesLeft;
  logic             r_write;
  logic             r_isCmd;
  logic [7:0]       r_txShift;
  logic [7:0]       r_rxShift;
  logic             r_rxPending;
  logic [7:0]       r_rxData;
  logic [7:0]       r_status;
  logic             r_rxValid;

  logic w_divLast, w_accept, w_rise, w_fall, w_byteEnd, w_lastByte;

  assign w_divLast  = (r_div == DIV_LAST);
  assign w_accept   = (r_state == S_IDLE) && start_in;
  assign w_rise     = w_divLast && ((r_state == S_SETUP) || (r_state == S_SHIFT && !r_phaseHigh));
  assign w_fall     = (r_state == S_SHIFT) && r_phaseHigh && w_divLast;
  assign w_byteEnd  = w_fall && (r_bitCnt == 3'd7);
  assign w_lastByte = (r_bytesLeft == '0);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_nextState = S_SETUP;
      S_SETUP: if (w_divLast) w_nextState = S_SHIFT;
      S_SHIFT: if (w_byteEnd && w_lastByte) w_nextState = S_HOLD;
      S_HOLD:  if (w_divLast) w_nextState = S_GAP;
      S_GAP:   if (w_divLast) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    ss_out       = 1'b1;
    sclk_out     = 1'b0;
    mosi_out     = 1'b0;
    busy_out     = 1'b0;
    done_out     = 1'b0;
    tx_ready_out = 1'b0;
    case (r_state)
      S_SETUP, S_HOLD: begin
        ss_out   = 1'b0;
        busy_out = 1'b1;
        mosi_out = r_txShift[7];
      end
      S_SHIFT: begin
        ss_out       = 1'b0;
        busy_out     = 1'b1;
        sclk_out     = r_phaseHigh;
        mosi_out     = r_txShift[7];
        tx_ready_out = w_byteEnd && !w_lastByte && r_write;
      end
      S_GAP: begin
        busy_out = 1'b1;
        done_out = w_divLast;
      end
      default: ;
    endcase
  end

  // Bytes-remaining counts down to zero and stops, so a full 2^LEN_W-1 length cannot wrap.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_div       <= '0;
      r_phaseHigh <= 1'b0;
      r_bitCnt    <= 3'd0;
      r_bytesLeft <= '0;
      r_write     <= 1'b0;
      r_isCmd     <= 1'b0;
      r_txShift   <= 8'h00;
      r_rxShift   <= 8'h00;
      r_rxPending <= 1'b0;
      r_rxData    <= 8'h00;
      r_status    <= 8'h00;
      r_rxValid   <= 1'b0;
    end else begin
      r_div       <= (r_state == S_IDLE || w_divLast) ? '0 : r_div + 1'b1;
      r_rxPending <= w_rise && (r_bitCnt == 3'd7);
      r_rxValid   <= 1'b0;
      if (w_accept) begin
        r_txShift   <= {reg_in, 1'b0, write_in, ackstat_in};
        r_write     <= write_in;
        r_bytesLeft <= len_in;
        r_bitCnt    <= 3'd0;
        r_phaseHigh <= 1'b0;
        r_isCmd     <= 1'b1;
      end
      if (w_rise) begin
        r_phaseHigh <= 1'b1;
        r_rxShift   <= {r_rxShift[6:0], miso_in};
      end
      if (w_fall) begin
        r_phaseHigh <= 1'b0;
        if (r_bitCnt == 3'd7) begin
          r_bitCnt <= 3'd0;
          r_isCmd  <= 1'b0;
          if (!w_lastByte) begin
            r_bytesLeft <= r_bytesLeft - 1'b1;
            r_txShift   <= r_write ? tx_data_in : 8'h00;
          end else begin
            r_txShift <= 8'h00;
          end
        end else begin
          r_bitCnt  <= r_bitCnt + 3'd1;
          r_txShift <= {r_txShift[6:0], 1'b0};
        end
      end
      if (r_rxPending) begin
        if (r_isCmd) begin
          r_status <= r_rxShift;
        end else if (!r_write) begin
          r_rxData  <= r_rxShift;
          r_rxValid <= 1'b1;
        end
      end
    end
  end

  assign rx_data_out  = r_rxData;
  assign rx_valid_out = r_rxValid;
  assign status_out   = r_status;

endmodule

// File: doc/max3421e_spi_master.md
Name: max3421e_spi_master

Overview:
- Transaction-level SPI master that sits directly downstream of usb_controller and drives the MAX3421E pins (usb_ss, usb_clk, usb_mosi, usb_miso).
- usb_controller requests one register access: register number, direction, ACKSTAT and byte count.
- The block shifts out the MAX3421E command byte, then streams data bytes out (write) or in (read).
- The status byte the chip returns during the command byte is captured.

Parameters:
- CLK_DIV, 2, clk_in cycles per SCLK half-period. Minimum 1. At 25 MHz, the default gives 6.25 MHz SCLK.
- LEN_W, 6, width of the byte-count input. Maximum data bytes per transaction is 2^LEN_W-1.

Ports:
- clk_in  input  1  system clock (25 MHz domain)
- rst_in  input  1  reset, asynchronous, active-low
- start_in  input  1  one-cycle request. Accepted only when busy_out=0.
- reg_in  input  5  MAX3421E register number
- write_in  input  1  1 = write transaction, 0 = read transaction
- ackstat_in  input  1  ACKSTAT bit of the command byte
- len_in  input  LEN_W  number of data bytes after the command byte. 0 is legal.
- tx_data_in  input  8  next write byte. Must be valid whenever tx_ready_out pulses.
- tx_ready_out  output  1  one-cycle pulse in the cycle tx_data_in is latched
- rx_data_out  output  8  last received data byte
- rx_valid_out  output  1  one-cycle pulse when rx_data_out updates
- status_out  output  8  status byte captured during the command byte
- busy_out  output  1  high from accept until transaction complete
- done_out  output  1  one-cycle pulse at completion
- ss_out  output  1  chip select, active-low
- sclk_out  output  1  SPI clock, mode 0 (idles low)
- mosi_out  output  1  master out
- miso_in  input  1  master in (synchronous to SCLK; no synchroniser required at these rates)

Behaviour:
- Reset value of every output (asynchronous assertion):
  - ss_out=1, sclk_out=0, mosi_out=0
  - busy_out=0, done_out=0, tx_ready_out=0, rx_valid_out=0
  - rx_data_out=0, status_out=0
- Reset mid-transaction aborts immediately: SS deasserts, no done_out. The state machine returns to IDLE on deassertion.
- Command byte = {reg_in, 1'b0, write_in, ackstat_in}. reg_in, write_in, ackstat_in and len_in are latched at accept. Later changes are ignored.
- State machine:
  - IDLE:
    - On start_in, go to SETUP.
    - ss_out=0 and busy_out=1 from the next cycle.
    - MOSI = command bit7.
  - SETUP: CLK_DIV cycles, SCLK low.
  - SHIFT, per bit:
    - SCLK high for CLK_DIV cycles; MISO is sampled on the rising edge.
    - SCLK low for CLK_DIV cycles; the next bit is driven on the falling edge.
    - MSB first.
  - HOLD: the low phase following the final bit; ss_out stays 0.
  - GAP:
    - ss_out=1 for CLK_DIV cycles.
    - On the last GAP cycle, done_out=1, and busy_out=0 from the next cycle.
- SS low duration is exactly CLK_DIV*(16*(1+len)+1) cycles. Total busy is that value plus CLK_DIV.
- The command byte's MISO bits go to status_out. It updates one cycle after the 8th rising edge of the command byte, with no rx_valid_out pulse.
- Write transactions:
  - tx_ready_out pulses, and tx_data_in is latched, in the cycle the last falling edge of the previous byte occurs.
  - bit7 of the latched byte is driven on that same edge.
  - MISO is ignored.
- Read transactions:
  - mosi_out=0 during data bytes.
  - rx_data_out updates and rx_valid_out pulses one cycle after the 8th rising edge of each data byte.
- len=0: command byte only. No tx_ready_out or rx_valid_out pulses.
- start_in while busy_out=1 is ignored. This includes the done_out cycle.
- A start_in in the cycle after busy_out falls is accepted, giving back-to-back transactions separated by the GAP.
- Byte and bit counters must not wrap. len=2^LEN_W-1 must transfer exactly that many bytes.

Test Plan:
- Write, CLK_DIV=2, reg=17, write=1, ack=0, len=1, tx=0xA5:
  - MOSI bytes 0x8A, 0xA5.
  - ss low exactly 66 cycles.
  - One tx_ready_out pulse.
  - done_out once; busy 68 cycles.
- Read, reg=13, len=2, MISO model returns status 0x3C then 0x12, 0x34:
  - status_out=0x3C.
  - rx_valid_out pulses twice, with 0x12 then 0x34.
  - MOSI = 0x68 then zeros.
- len=0, reg=18, write=1, ack=1:
  - Only byte 0x93 shifted.
  - ss low 34 cycles (CLK_DIV=2).
  - No tx_ready_out or rx_valid_out pulses.
- start_in pulsed mid-transfer and in the done_out cycle:
  - Both ignored.
  - A start the cycle after busy falls is accepted, with a CLK_DIV-cycle SS-high gap.
- Reset asserted halfway through the second data byte:
  - ss_out=1, sclk_out=0, busy_out=0 asynchronously.
  - No done_out.
  - A new transaction after release completes normally.
- CLK_DIV=1, len=63 write with incrementing tx bytes:
  - 64 bytes shifted with correct order.
  - ss low 1025 cycles.
  - 63 tx_ready_out pulses.
